// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS test sequencer.
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam int BYTES_PER_PATTERN = 4;

endpackage

// File: rtl/prbs_test_sequencer_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_q <= '0;
        end else if (i_inc && !(&r_q)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/prbs_test_sequencer.sv
// Run controller for the PRBS generator + pattern detector: loads config,
// times a detection window, reports pass/fail and keeps saturating tallies.
module prbs_test_sequencer
    import prbs_pkg::*;
#(
    parameter int MARGIN  = 16,
    parameter int CNT_W   = 11,
    parameter int TALLY_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               abort,
    input  logic               soak,
    input  logic [31:0]        cfg_pattern,
    input  logic [7:0]         cfg_n,
    output logic               dp_rstn,
    output logic [31:0]        dp_in,
    output logic [7:0]         dp_n,
    input  logic               pattern_detected,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [TALLY_W-1:0] pass_cnt,
    output logic [TALLY_W-1:0] fail_cnt
);

    seq_state_t       r_state;
    logic [31:0]      r_dp_in;
    logic [7:0]       r_dp_n;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pass;
    logic             r_fail;
    logic [CNT_W-1:0] w_limit;
    logic             w_done;

    // Window limit is 4*n + MARGIN; CNT_W is sized so this never overflows.
    assign w_limit = CNT_W'(r_dp_n) * CNT_W'(BYTES_PER_PATTERN) + CNT_W'(MARGIN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_dp_in <= '0;
            r_dp_n  <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dp_in <= cfg_pattern;
                        r_dp_n  <= cfg_n;
                        r_pass  <= 1'b0;
                        if (cfg_n == 8'd0) begin
                            r_fail  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_fail  <= 1'b0;
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    r_cnt <= '0;
                    if (abort) begin
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Abort beats timeout, and timeout beats a same-cycle detect.
                    if (abort) begin
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt >= w_limit) begin
                        r_fail  <= 1'b1;
                        r_state <= DONE;
                    end else if (pattern_detected) begin
                        r_pass  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (abort || soak) begin
                        r_pass <= 1'b0;
                        r_fail <= 1'b0;
                    end
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (soak) begin
                        r_state <= LOAD;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // An abort landing on the DONE cycle suppresses both the pulse and the tally.
    assign w_done = (r_state == DONE) && !abort;

    sat_counter #(.W(TALLY_W)) u_pass_cnt (
        .clk   (CLK),
        .rst   (RST),
        .i_inc (w_done && r_pass),
        .i_clr (1'b0),
        .o_q   (pass_cnt)
    );

    sat_counter #(.W(TALLY_W)) u_fail_cnt (
        .clk   (CLK),
        .rst   (RST),
        .i_inc (w_done && r_fail),
        .i_clr (1'b0),
        .o_q   (fail_cnt)
    );

    assign dp_rstn = (r_state == RUN);
    assign dp_in   = r_dp_in;
    assign dp_n    = r_dp_n;
    assign busy    = (r_state != IDLE);
    assign done    = w_done;
    assign pass    = r_pass;
    assign fail    = r_fail;

endmodule
